sample_packer: RTL and testbench

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sample_packer.sv | 145 ++++++++++++++
 tb/tb_sample_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// Packs pairs of 14-bit ADC samples into 32-bit words (first sample in [15:0])
// and buffers them in a first-word-fall-through FIFO with drop accounting.
module sample_packer #(
    parameter int unsigned DEPTH       = 16,
    parameter bit          SIGN_EXTEND = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CLEAR,
    input  logic                     ENABLE,
    input  logic [13:0]              SAMPLE,
    input  logic                     SAMPLE_VALID,
    output logic [31:0]              WORD_DATA,
    output logic                     WORD_VALID,
    input  logic                     WORD_READY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic [15:0]              DROP_COUNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     hold_q, hold_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [PW-1:0]   level_d;
    logic [31:0]     head_d;
    logic [31:0]     mem [DEPTH];
    logic            armed_q;

    logic [15:0]     sample_pad;
    logic [31:0]     push_word;
    logic            accept, push, pop, full, empty, wr_en, drop;

    assign sample_pad = SIGN_EXTEND ? {{2{SAMPLE[13]}}, SAMPLE} : {2'b00, SAMPLE};
    assign push_word  = {sample_pad, hold_q};
    assign full       = (LEVEL == PW'(DEPTH));
    assign empty      = (LEVEL == '0);
    // armed_q masks the edge on which reset is released
    assign accept     = armed_q & SAMPLE_VALID & ENABLE & ~CLEAR;
    assign pop        = armed_q & ~CLEAR & ~empty & WORD_READY;
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;

    // Pack FSM: next state, holding register, push strobe
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        push    = 1'b0;
        if (!armed_q) begin
            state_d = state_q;
        end else if (CLEAR) begin
            state_d = ST_LOW;
            hold_d  = 16'h0;
        end else if (!ENABLE) begin
            state_d = ST_LOW;
        end else if (accept) begin
            case (state_q)
                ST_LOW: begin
                    hold_d  = sample_pad;
                    state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    push    = 1'b1;
                    state_d = ST_LOW;
                end
                default: state_d = ST_LOW;
            endcase
        end
    end

    // FIFO bookkeeping and the registered head word
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        level_d  = LEVEL + PW'(wr_en) - PW'(pop);
        if (level_d == '0) begin
            head_d = 32'h0;
        end else if ((LEVEL - PW'(pop)) == '0) begin
            head_d = push_word;
        end else begin
            head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_q    <= 1'b0;
            hold_q     <= 16'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            LEVEL      <= '0;
            WORD_VALID <= 1'b0;
            WORD_DATA  <= 32'h0;
            OVERFLOW   <= 1'b0;
            DROP_COUNT <= 16'h0;
        end else begin
            armed_q <= 1'b1;
            hold_q  <= hold_d;
            if (armed_q && CLEAR) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                LEVEL      <= '0;
                WORD_VALID <= 1'b0;
                WORD_DATA  <= 32'h0;
                OVERFLOW   <= 1'b0;
                DROP_COUNT <= 16'h0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                LEVEL      <= level_d;
                WORD_VALID <= (level_d != '0);
                WORD_DATA  <= head_d;
                if (drop) begin
                    OVERFLOW <= 1'b1;
                    if (DROP_COUNT != 16'hFFFF) begin
                        DROP_COUNT <= DROP_COUNT + 16'd1;
                    end
                end
            end
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer against a queue-based packing model.
module tb_sample_packer;

    localparam int unsigned DEPTH = 16;
    localparam bit          SE    = 1'b1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CLEAR = 1'b0;
    logic        ENABLE = 1'b0;
    logic [13:0] SAMPLE = '0;
    logic        SAMPLE_VALID = 1'b0;
    logic        WORD_READY = 1'b0;
    logic [31:0] WORD_DATA;
    logic        WORD_VALID;
    logic [4:0]  LEVEL;
    logic        OVERFLOW;
    logic [15:0] DROP_COUNT;

    sample_packer #(.DEPTH(DEPTH), .SIGN_EXTEND(SE)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .ENABLE(ENABLE),
        .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
        .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
        .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .DROP_COUNT(DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: queue of packed words plus a pending half
    logic [31:0] mq[$];
    logic [15:0] m_half;
    bit          m_hv;
    bit          m_ovf;
    int          m_drop;

    function automatic logic [15:0] pad(input logic [13:0] s);
        return SE ? {{2{s[13]}}, s} : {2'b00, s};
    endfunction

    function automatic logic [31:0] m_head();
        return (mq.size() != 0) ? mq[0] : 32'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hv   = 1'b0;
        m_half = 16'h0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // Called at a negedge: drive inputs, advance model, return at next negedge
    task automatic cycle(input bit v, input logic [13:0] s, input bit en, input bit rdy, input bit clr);
        bit          do_pop;
        bit          do_push;
        logic [31:0] w;
        SAMPLE_VALID = v;
        SAMPLE       = s;
        ENABLE       = en;
        WORD_READY   = rdy;
        CLEAR        = clr;
        do_push      = 1'b0;
        w            = 32'h0;
        if (clr) begin
            model_reset();
        end else begin
            do_pop = (mq.size() != 0) && rdy;
            if (!en) begin
                m_hv = 1'b0;
            end else if (v) begin
                if (!m_hv) begin
                    m_half = pad(s);
                    m_hv   = 1'b1;
                end else begin
                    w       = {pad(s), m_half};
                    m_hv    = 1'b0;
                    do_push = 1'b1;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++; if (LEVEL !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", LEVEL); end
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", WORD_VALID); end
        checks++; if (WORD_DATA !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", WORD_DATA); end
        checks++; if (OVERFLOW !== 1'b0 || DROP_COUNT !== 16'h0) begin errors++; $display("FAIL reset_ovf got %b/%0d exp 0/0", OVERFLOW, DROP_COUNT); end
        @(negedge CLK);
        SAMPLE_VALID = 1'b1; ENABLE = 1'b1; SAMPLE = 14'h0123;
        #4 RST_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cycle(1, 14'h0AAA, 1, 0, 0);
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL release_edge_ignored got valid %b exp 0", WORD_VALID); end
        cycle(1, 14'h0555, 1, 0, 0);
        checks++; if (WORD_DATA !== 32'h05550AAA) begin errors++; $display("FAIL release_first_word got %h exp 05550aaa", WORD_DATA); end
        cycle(0, 14'h0, 1, 1, 0);
        checks++; if (LEVEL !== 5'd0) begin errors++; $display("FAIL release_drain got %0d exp 0", LEVEL); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w;
        exp_w = SE ? 32'hE0001FFF : 32'h20001FFF;
        cycle(1, 14'h1FFF, 1, 1, 0);
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL basic_half got valid %b exp 0", WORD_VALID); end
        cycle(1, 14'h2000, 1, 1, 0);
        checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL basic_latency got valid %b exp 1", WORD_VALID); end
        checks++; if (WORD_DATA !== exp_w) begin errors++; $display("FAIL basic_word got %h exp %h", WORD_DATA, exp_w); end
        cycle(0, 14'h0, 1, 1, 0);
        checks++; if (WORD_VALID !== 1'b0 || LEVEL !== 5'd0) begin errors++; $display("FAIL basic_pop got %b/%0d exp 0/0", WORD_VALID, LEVEL); end
    endtask

    task automatic test_overflow_and_wrap();
        logic [13:0] s0, s1, s;
        s0 = 14'($urandom);
        s1 = 14'($urandom);
        cycle(1, s0, 1, 0, 0);
        cycle(1, s1, 1, 0, 0);
        for (int i = 2; i < 40; i++) cycle(1, 14'($urandom), 1, 0, 0);
        checks++; if (LEVEL !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", LEVEL); end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", OVERFLOW); end
        checks++; if (DROP_COUNT !== 16'd4) begin errors++; $display("FAIL ovf_drops got %0d exp 4", DROP_COUNT); end
        checks++; if (WORD_DATA !== {pad(s1), pad(s0)}) begin errors++; $display("FAIL ovf_first_pair got %h exp %h", WORD_DATA, {pad(s1), pad(s0)}); end
        // Full FIFO: ready only on pushing edges keeps it full across wrap
        for (int i = 0; i < 40; i++) begin
            s = 14'($urandom);
            cycle(1, s, 1, m_hv, 0);
            checks++; if (LEVEL !== 5'd16 || DROP_COUNT !== 16'd4) begin errors++; $display("FAIL wrap_level[%0d] got %0d/%0d exp 16/4", i, LEVEL, DROP_COUNT); end
            checks++; if (WORD_DATA !== m_head()) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, WORD_DATA, m_head()); end
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== m_head()) begin errors++; $display("FAIL drain[%0d] got %b/%h exp 1/%h", i, WORD_VALID, WORD_DATA, m_head()); end
            cycle(0, 14'h0, 1, 1, 0);
        end
        checks++; if (LEVEL !== 5'd0 || WORD_VALID !== 1'b0) begin errors++; $display("FAIL drain_empty got %0d/%b exp 0/0", LEVEL, WORD_VALID); end
    endtask

    task automatic test_enable();
        logic [31:0] exp_w;
        exp_w = SE ? 32'hF3330222 : 32'h33330222;
        cycle(0, 14'h0, 1, 1, 1);
        cycle(1, 14'h0111, 1, 0, 0);
        cycle(0, 14'h0, 0, 0, 0);
        cycle(1, 14'h0222, 1, 0, 0);
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL enable_discard got valid %b exp 0", WORD_VALID); end
        cycle(1, 14'h3333, 1, 0, 0);
        checks++; if (LEVEL !== 5'd1 || WORD_DATA !== exp_w) begin errors++; $display("FAIL enable_word got %0d/%h exp 1/%h", LEVEL, WORD_DATA, exp_w); end
        cycle(0, 14'h0, 1, 1, 0);
        checks++; if (LEVEL !== 5'd0) begin errors++; $display("FAIL enable_single got %0d exp 0", LEVEL); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 36; i++) cycle(1, 14'($urandom), 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 14'h0, 1, 1, 0);
        cycle(1, 14'h1234, 1, 0, 0);
        checks++; if (LEVEL !== 5'd7 || OVERFLOW !== 1'b1 || DROP_COUNT !== 16'd2) begin errors++; $display("FAIL clear_setup got %0d/%b/%0d exp 7/1/2", LEVEL, OVERFLOW, DROP_COUNT); end
        cycle(1, 14'h0777, 1, 1, 1);
        checks++; if (LEVEL !== 5'd0 || WORD_VALID !== 1'b0) begin errors++; $display("FAIL clear_level got %0d/%b exp 0/0", LEVEL, WORD_VALID); end
        checks++; if (OVERFLOW !== 1'b0 || DROP_COUNT !== 16'd0) begin errors++; $display("FAIL clear_ovf got %b/%0d exp 0/0", OVERFLOW, DROP_COUNT); end
        checks++; if (WORD_DATA !== 32'h0) begin errors++; $display("FAIL clear_data got %h exp 0", WORD_DATA); end
        cycle(1, 14'h0001, 1, 0, 0);
        cycle(1, 14'h0002, 1, 0, 0);
        checks++; if (WORD_DATA !== 32'h00020001 || LEVEL !== 5'd1) begin errors++; $display("FAIL clear_realign got %h/%0d exp 00020001/1", WORD_DATA, LEVEL); end
        cycle(0, 14'h0, 1, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) cycle(1, 14'($urandom), 1, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        checks++; if (LEVEL !== 5'd0 || WORD_VALID !== 1'b0) begin errors++; $display("FAIL areset_level got %0d/%b exp 0/0", LEVEL, WORD_VALID); end
        checks++; if (WORD_DATA !== 32'h0 || OVERFLOW !== 1'b0 || DROP_COUNT !== 16'h0) begin errors++; $display("FAIL areset_outs got %h/%b/%0d exp 0/0/0", WORD_DATA, OVERFLOW, DROP_COUNT); end
        model_reset();
        SAMPLE_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #3 RST_N = 1'b1;
        @(negedge CLK);
        cycle(1, 14'h0010, 1, 0, 0);
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL areset_no_stale got valid %b exp 0", WORD_VALID); end
        cycle(1, 14'h0020, 1, 0, 0);
        checks++; if (WORD_DATA !== 32'h00200010 || LEVEL !== 5'd1) begin errors++; $display("FAIL areset_word got %h/%0d exp 00200010/1", WORD_DATA, LEVEL); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 4) != 0, 14'($urandom), ($urandom % 16) != 0,
                  ($urandom % 3) == 0, ($urandom % 128) == 0);
            checks++; if (LEVEL !== 5'(mq.size())) begin errors++; $display("FAIL rand_level[%0d] got %0d exp %0d", i, LEVEL, mq.size()); end
            checks++; if (WORD_VALID !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d] got %b", i, WORD_VALID); end
            checks++; if (WORD_DATA !== m_head()) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, WORD_DATA, m_head()); end
            checks++; if (OVERFLOW !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d] got %b exp %b", i, OVERFLOW, m_ovf); end
            checks++; if (DROP_COUNT !== 16'(m_drop)) begin errors++; $display("FAIL rand_drops[%0d] got %0d exp %0d", i, DROP_COUNT, m_drop); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow_and_wrap();
        test_enable();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
